// File: rtl/conv_tree_deserializer.sv
// Serial-to-8-bit deserializer: sync-pattern hunt (CONV_DESER_SYNC_HUNT_EN), bit-slip, resync.
// Latency: word registered on the edge sampling its 8th bit; word_valid_o is a one-cycle pulse.
// Backpressure: none, one bit accepted every cycle; slip_i drops the current bit while locked.
module conv_tree_deserializer #(
    parameter logic [7:0] SYNC_PATTERN = 8'hA5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic serial_in_i,
    input  logic slip_i,
    input  logic resync_i,
    output logic par_out1_o,
    output logic par_out2_o,
    output logic par_out3_o,
    output logic par_out4_o,
    output logic par_out5_o,
    output logic par_out6_o,
    output logic par_out7_o,
    output logic par_out8_o,
    output logic word_valid_o,
    output logic word_is_sync_o,
    output logic locked_o
);

    logic [7:0] win_q, win_d;
    logic [7:0] par_q, par_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       vld_q, vld_d;
    logic       is_sync_q, is_sync_d;
    logic [7:0] win_shift;
    logic       locked;

    // Oldest bit sits at index 0 (PAR_OUT1), newest enters at index 7.
    assign win_shift = {serial_in_i, win_q[7:1]};

`ifdef CONV_DESER_SYNC_HUNT_EN
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] fill_q, fill_d;
    logic       sync_hit;

    // Only a fully populated window may match.
    assign sync_hit = (fill_q >= 4'd7) && (win_shift == SYNC_PATTERN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HUNT;
            fill_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (resync_i) begin
            state_d = ST_HUNT;
        end else if (state_q == ST_HUNT && sync_hit) begin
            state_d = ST_LOCKED;
        end
    end

    always_comb begin
        locked_o = (state_q == ST_LOCKED);
    end

    assign locked = (state_q == ST_LOCKED);

    always_comb begin
        fill_d = fill_q;
        if (resync_i) begin
            fill_d = 4'd0;
        end else if (!locked && fill_q != 4'd8) begin
            fill_d = fill_q + 4'd1;
        end
    end
`else
    assign locked   = 1'b1;
    assign locked_o = 1'b1;
`endif

    always_comb begin
        win_d     = win_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        vld_d     = 1'b0;
        is_sync_d = 1'b0;
        if (resync_i) begin
            bit_cnt_d = 3'd0;
        end else if (!(locked && slip_i)) begin
            win_d = win_shift;
            if (locked) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    par_d     = win_shift;
                    vld_d     = 1'b1;
                    is_sync_d = (win_shift == SYNC_PATTERN);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q     <= 8'd0;
            par_q     <= 8'd0;
            bit_cnt_q <= 3'd0;
            vld_q     <= 1'b0;
            is_sync_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            vld_q     <= vld_d;
            is_sync_q <= is_sync_d;
        end
    end

    assign {par_out8_o, par_out7_o, par_out6_o, par_out5_o,
            par_out4_o, par_out3_o, par_out2_o, par_out1_o} = par_q;
    assign word_valid_o   = vld_q;
    assign word_is_sync_o = is_sync_q;

endmodule
